// File: rtl/codificador_botoes_fila_if.sv
// Consumer-side bus of the button encoder: show-ahead FIFO head, status flags and pop strobe.
interface codificador_botoes_fila_if #(parameter int W = 2);
   logic         ler;
   logic [W-1:0] codigo;
   logic         valido;
   logic         cheio;
   logic         multiplo;
   logic         descartado;

   modport master (input ler, output codigo, valido, cheio, multiplo, descartado);
   modport slave  (output ler, input codigo, valido, cheio, multiplo, descartado);
endinterface

// File: rtl/codificador_botoes_fila.sv
// Debounced N-button encoder: sync + debounce per channel, press-edge encoding,
// show-ahead FIFO of codes with simultaneous-press and overflow flags.
module codificador_botoes_fila #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int FIFO_PROF       = 4,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_BOTOES-1:0]   botoes,
   codificador_botoes_fila_if.master fila
);
   localparam int W  = $clog2(N_BOTOES);
   localparam int PW = $clog2(FIFO_PROF);
   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

   logic [N_BOTOES-1:0] botoes_int_s;
   logic [N_BOTOES-1:0] s1_r, s2_r, estavel_r, estavel_d_r;
   logic [CW-1:0]       cnt_r [N_BOTOES];
   logic [N_BOTOES-1:0] pressao_s;
   logic                um_s, multi_s, push_s, pop_s, push_ok_s, cheio_s, vazio_s;
   logic [W-1:0]        codigo_novo_s;
   logic [W-1:0]        mem_r [FIFO_PROF];
   logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
   logic [PW:0]         ocup_r;
   logic                multiplo_r, descartado_r;

   assign botoes_int_s = ATIVO_BAIXO ? ~botoes : botoes;

   // Synchroniser chain, debounce counters and stable-level history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r        <= '0;
         s2_r        <= '0;
         estavel_r   <= '0;
         estavel_d_r <= '0;
         for (int i = 0; i < N_BOTOES; i++) cnt_r[i] <= '0;
      end else begin
         s1_r        <= botoes_int_s;
         s2_r        <= s1_r;
         estavel_d_r <= estavel_r;
         for (int i = 0; i < N_BOTOES; i++) begin
            if (s2_r[i] == estavel_r[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
               estavel_r[i] <= s2_r[i];
               cnt_r[i]     <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + CW'(1);
            end
         end
      end
   end

   assign pressao_s = estavel_r & ~estavel_d_r;

   // Count press edges (one vs. several) and encode the single-press channel.
   always_comb begin
      um_s          = 1'b0;
      multi_s       = 1'b0;
      codigo_novo_s = '0;
      for (int i = 0; i < N_BOTOES; i++) begin
         multi_s       = multi_s | (pressao_s[i] & um_s);
         um_s          = um_s | pressao_s[i];
         codigo_novo_s = pressao_s[i] ? W'(N_BOTOES - 1 - i) : codigo_novo_s;
      end
   end

   assign vazio_s   = (ocup_r == '0);
   assign cheio_s   = (ocup_r == (PW+1)'(FIFO_PROF));
   assign push_s    = um_s & ~multi_s;
   assign pop_s     = fila.ler & ~vazio_s;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign push_ok_s = push_s & (~cheio_s | pop_s);

   // FIFO pointers, occupancy and the one-cycle event flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         ocup_r       <= '0;
         multiplo_r   <= 1'b0;
         descartado_r <= 1'b0;
      end else begin
         multiplo_r   <= multi_s;
         descartado_r <= push_s & cheio_s & ~pop_s;
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push_ok_s, pop_s})
            2'b10:   ocup_r <= ocup_r + (PW+1)'(1);
            2'b01:   ocup_r <= ocup_r - (PW+1)'(1);
            default: ocup_r <= ocup_r;
         endcase
      end
   end

   // Code storage; contents are only observed through a non-zero occupancy.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r] <= codigo_novo_s;
   end

   assign fila.codigo     = vazio_s ? '0 : mem_r[rd_ptr_r];
   assign fila.valido     = ~vazio_s;
   assign fila.cheio      = cheio_s;
   assign fila.multiplo   = multiplo_r;
   assign fila.descartado = descartado_r;
endmodule

// File: tb/tb_codificador_botoes_fila.sv
// Self-checking bench: directed vector table, hand sequences and a random run
// against a window/queue reference model of the button encoder.
module tb_codificador_botoes_fila;
   localparam int N  = 4;
   localparam int D  = 4;
   localparam int FP = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] botoes;

   codificador_botoes_fila_if #(.W(2)) fila ();

   codificador_botoes_fila #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D), .FIFO_PROF(FP), .ATIVO_BAIXO(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .botoes (botoes),
      .fila   (fila)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int desc_seen = 0;

   // Reference model state: 2-stage sync, last-D sample window, pending presses, code queue.
   logic [N-1:0] m_s1, m_s2, m_est, m_pend;
   bit           win [N][$];
   int unsigned  q [$];
   logic         e_mult, e_desc;

   typedef struct {
      logic [3:0] b;
      logic       l;
      int         n;
      logic       v;
      logic [1:0] c;
      logic       f;
      logic       m;
      logic       d;
   } vec_t;
   vec_t tab [16];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_est = '0; m_pend = '0;
      for (int c = 0; c < N; c++) win[c].delete();
      q.delete();
      e_mult = 1'b0; e_desc = 1'b0;
   endtask

   task automatic model_edge(input logic [N-1:0] pr, input logic l);
      int  pn, pc;
      bit  pop, push, all;
      pn = 0; pc = 0;
      for (int c = 0; c < N; c++) if (m_pend[c]) begin pn++; pc = c; end
      pop    = l && (q.size() > 0);
      push   = (pn == 1);
      e_mult = (pn >= 2);
      e_desc = push && (q.size() == FP) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !e_desc) q.push_back(N - 1 - pc);
      for (int c = 0; c < N; c++) begin
         m_pend[c] = 1'b0;
         win[c].push_back(m_s2[c]);
         if (win[c].size() > D) void'(win[c].pop_front());
         if (win[c].size() == D) begin
            all = 1'b1;
            foreach (win[c][j]) if (win[c][j] == m_est[c]) all = 1'b0;
            if (all) begin
               m_est[c]  = ~m_est[c];
               m_pend[c] = m_est[c];
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = pr;
   endtask

   task automatic model_cmp();
      int ev;
      ev = (q.size() > 0) ? 1 : 0;
      chk("mdl_valido", fila.valido, ev);
      chk("mdl_codigo", fila.codigo, ev ? q[0] : 0);
      chk("mdl_cheio", fila.cheio, (q.size() == FP) ? 1 : 0);
      chk("mdl_multiplo", fila.multiplo, e_mult);
      chk("mdl_descartado", fila.descartado, e_desc);
   endtask

   // One clock: model follows the inputs seen at the edge, outputs compared at the falling edge.
   task automatic step();
      logic [N-1:0] pr;
      logic         l, r;
      pr = ~botoes;
      l  = fila.ler;
      r  = rst_n;
      @(posedge clk);
      if (!r) model_reset();
      else    model_edge(pr, l);
      @(negedge clk);
      model_cmp();
      if (fila.descartado) desc_seen++;
   endtask

   task automatic press(input int ch, input int ler_at);
      for (int i = 1; i <= 10; i++) begin
         botoes     = 4'b1111;
         botoes[ch] = 1'b0;
         fila.ler   = (i == ler_at);
         step();
      end
      fila.ler = 1'b0;
      botoes   = 4'b1111;
      repeat (10) step();
   endtask

   task automatic pop_expect(input int exp);
      chk("pop_valido", fila.valido, 1);
      chk("pop_codigo", fila.codigo, exp);
      fila.ler = 1'b1;
      step();
      fila.ler = 1'b0;
   endtask

   initial begin
      tab[0]  = '{4'b1111, 1'b0, 20, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[1]  = '{4'b1011, 1'b0,  6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[2]  = '{4'b1011, 1'b0,  1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
      tab[3]  = '{4'b1011, 1'b1,  1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[4]  = '{4'b1011, 1'b0, 20, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[5]  = '{4'b1111, 1'b0, 10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[6]  = '{4'b1110, 1'b0,  2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[7]  = '{4'b1111, 1'b0,  2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[8]  = '{4'b1110, 1'b0,  6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[9]  = '{4'b1110, 1'b0,  1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
      tab[10] = '{4'b1110, 1'b1,  1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[11] = '{4'b1111, 1'b0, 10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[12] = '{4'b0101, 1'b0,  6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[13] = '{4'b0101, 1'b0,  1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      tab[14] = '{4'b0101, 1'b0,  5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tab[15] = '{4'b1111, 1'b0, 10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

      rst_n    = 1'b0;
      botoes   = 4'b1111;
      fila.ler = 1'b0;
      model_reset();
      @(negedge clk);
      repeat (3) step();
      chk("reset_valido", fila.valido, 0);
      chk("reset_multiplo", fila.multiplo, 0);
      rst_n = 1'b1;

      // Directed table: idle, clean press, bounce, simultaneous press.
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < tab[r].n; k++) begin
            botoes   = tab[r].b;
            fila.ler = tab[r].l;
            step();
            chk($sformatf("tab%0d_valido", r), fila.valido, tab[r].v);
            chk($sformatf("tab%0d_codigo", r), fila.codigo, tab[r].c);
            chk($sformatf("tab%0d_cheio", r), fila.cheio, tab[r].f);
            chk($sformatf("tab%0d_multiplo", r), fila.multiplo, tab[r].m);
            chk($sformatf("tab%0d_descartado", r), fila.descartado, tab[r].d);
         end
      end
      fila.ler = 1'b0;

      // Overflow: four presses fill, the fifth is dropped.
      desc_seen = 0;
      press(3, 0); press(2, 0); press(1, 0);
      chk("cheio_after3", fila.cheio, 0);
      press(0, 0);
      chk("cheio_after4", fila.cheio, 1);
      chk("desc_before5", desc_seen, 0);
      press(3, 0);
      chk("desc_on5", desc_seen, 1);
      chk("cheio_after5", fila.cheio, 1);
      pop_expect(0); pop_expect(1); pop_expect(2); pop_expect(3);
      chk("empty_after_pops", fila.valido, 0);

      // Pointer wrap: six more single push/pop pairs.
      press(2, 0); pop_expect(1);
      press(0, 0); pop_expect(3);
      press(1, 0); press(3, 0); press(2, 0);
      pop_expect(2); pop_expect(0);
      press(0, 0); pop_expect(1); pop_expect(3);

      // Full FIFO with push and pop on the same edge.
      press(0, 0); press(1, 0); press(2, 0); press(3, 0);
      chk("full_before", fila.cheio, 1);
      desc_seen = 0;
      press(1, 7);
      chk("fullpp_desc", desc_seen, 0);
      chk("fullpp_cheio", fila.cheio, 1);
      pop_expect(2); pop_expect(1); pop_expect(0); pop_expect(2);

      // Asynchronous reset mid-stream, button held through reset release.
      press(3, 0);
      botoes = 4'b1101;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_valido", fila.valido, 0);
      chk("async_codigo", fila.codigo, 0);
      chk("async_cheio", fila.cheio, 0);
      model_reset();
      @(negedge clk);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (30) step();
      chk("held_reset_valido", fila.valido, 1);
      chk("held_reset_codigo", fila.codigo, 2);
      pop_expect(2);
      botoes = 4'b1111;
      repeat (10) step();
      chk("held_one_code", fila.valido, 0);

      // Random buttons with sticky levels and sparse pops against the model.
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            int c;
            c = $urandom_range(0, N - 1);
            botoes[c] = ~botoes[c];
         end
         fila.ler = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/codificador_botoes_fila.md
Name: codificador_botoes_fila

Overview:
- Parametrised, clocked successor to the combinational button encoder.
- Accepts N raw (bouncing, asynchronous) push-buttons and synchronises and debounces each one.
- Detects press edges, encodes each valid single press into a binary code and buffers the codes in a small show-ahead FIFO that the control FSM drains with a read strobe.
- Flags simultaneous presses and FIFO overflow.

Parameters:
- N_BOTOES, 4, number of button inputs (>=2); code width W = clog2(N_BOTOES), derived internally, not overridable.
- DEBOUNCE_CICLOS, 4, consecutive stable samples required to accept a level change (>=1).
- FIFO_PROF, 4, FIFO depth in entries (power of 2, >=2).
- ATIVO_BAIXO, 1, 1 = raw buttons read 0 when pressed (board default); 0 = active-high.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- botoes  in  N_BOTOES  raw button levels, asynchronous to clk.
- ler  in  1  pop strobe; consumes head entry when valido=1.
- codigo  out  W  head-of-FIFO code; 0 when empty.
- valido  out  1  FIFO non-empty; codigo is meaningful.
- cheio  out  1  FIFO holds FIFO_PROF entries.
- multiplo  out  1  one-cycle pulse: more than one press edge in the same cycle.
- descartado  out  1  one-cycle pulse: single press lost because FIFO full and no pop.

Behaviour:
- Reset (rst_n=0, async): sync FFs and stable levels = released, debounce counters = 0, FIFO empty.
  - Outputs while in reset: codigo=0, valido=0, cheio=0, multiplo=0, descartado=0.
  - Reset asserted mid-operation discards all buffered codes and in-flight debounce state.
- Polarity: inputs inverted when ATIVO_BAIXO=1, so internally 1 = pressed.
- Synchroniser: 2-FF chain per channel (s1, s2).
- Debounce, per channel:
  - Counter increments each cycle s2 != estavel.
  - Counter clears on any cycle s2 == estavel; a bounce restarts the count.
  - estavel takes s2 on the edge where the DEBOUNCE_CICLOS-th consecutive differing sample is seen; counter clears.
- Press edge: estavel 0->1. Release edges produce nothing.
- Encoding: channel i maps to code N_BOTOES-1-i (N=4: b3->00, b2->01, b1->10, b0->11).
- Per cycle, with E = number of press edges:
  - E=0: no push.
  - E=1: push the code.
  - E>=2: no push; multiplo=1 for exactly that cycle.
- Latency: counting the first edge that samples the new raw level as edge 1, estavel updates on edge 2+DEBOUNCE_CICLOS and the code is written (valido rises if empty) on edge 3+DEBOUNCE_CICLOS. Default: edge 7.
- FIFO:
  - Show-ahead: codigo reflects head combinationally from registered storage.
  - Pop occurs when ler=1 and valido=1. ler while empty is ignored, with no state change.
  - Push and pop in the same cycle:
    - Non-empty, non-full: count unchanged, order preserved.
    - Full: both accepted, stays full, descartado=0.
    - Empty: push accepted, pop ignored; valido=1 next cycle.
  - Push when full without pop: code dropped, descartado=1 for one cycle, contents unchanged.
  - Pointers are log2(FIFO_PROF) bits and wrap naturally. An occupancy counter of log2(FIFO_PROF)+1 bits drives cheio and valido.
- Button held through reset release: debounced as a fresh press and produces exactly one code.
- Button held indefinitely: exactly one code, no auto-repeat.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 for 3 cycles with botoes=4'b1111 (ATIVO_BAIXO=1), then release reset.
  - Response: all outputs 0, and they remain 0 for 20 cycles.
- Clean press latency:
  - Stimulus: drive botoes[2]=0 starting before edge 1 and hold.
  - Response: valido=1 and codigo=2'b01 after edge 7 (not before). Pulse ler once: valido=0 the next cycle. Holding the button yields no second code.
- Bounce:
  - Stimulus: botoes[0] toggles 0/1/0 with 2-cycle intervals, then holds 0.
  - Response: exactly one code 2'b11, appearing 7 edges after the final stable transition.
- Simultaneous press:
  - Stimulus: botoes[3] and botoes[1] go low on the same cycle.
  - Response: multiplo pulses once, for one cycle, on edge 7; valido stays 0.
- Overflow and wrap:
  - Stimulus: with no ler, deliver 5 sequential single presses b3, b2, b1, b0, b3.
  - Response: cheio=1 after the 4th; descartado pulses on the 5th. Pops read 00, 01, 10, 11 in order.
  - Continue: then push/pop 6 more entries, checking FIFO order across pointer wrap.
- Full push+pop and async reset:
  - Stimulus: with the FIFO full, assert ler in the same cycle as a new press.
  - Response: descartado=0, cheio stays 1, and the new code is last out.
  - Continue: assert rst_n=0 mid-stream. Response: valido=0 immediately, without waiting for clk.
